// File: rtl/pe_typed_stream.sv
// Streaming divide/sqrt PE: wraps the fixed-latency FP cores, keeps results in accept order,
// and uses a credit counter so the output FIFO absorbs consumer stalls without overflowing.

// Functional stand-in for the floating_point_div core: same ports, fixed latency, round-to-nearest-even,
// denormal inputs and outputs flushed to zero.
module floating_point_div #(
    parameter int LATENCY = 29
) (
    input  logic        aclk,
    input  logic        s_axis_a_tvalid,
    input  logic [63:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [63:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [63:0] m_axis_result_tdata
);

    function automatic logic [63:0] fp_div(input logic [63:0] a, input logic [63:0] b);
        logic              sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic              guard, sticky;
        logic [10:0]       ea, eb;
        logic [107:0]      num, den;
        logic [55:0]       q;
        logic [52:0]       mant;
        logic [53:0]       rnd;
        logic signed [12:0] e;
        sign   = a[63] ^ b[63];
        ea     = a[62:52];
        eb     = b[62:52];
        a_nan  = (ea == 11'h7FF) && (a[51:0] != '0);
        b_nan  = (eb == 11'h7FF) && (b[51:0] != '0);
        a_inf  = (ea == 11'h7FF) && (a[51:0] == '0);
        b_inf  = (eb == 11'h7FF) && (b[51:0] == '0);
        a_zero = (ea == 11'h000);
        b_zero = (eb == 11'h000);
        // Quotient of the 53-bit significands scaled by 2^55 leaves two rounding bits below the LSB.
        num    = {1'b1, a[51:0], 55'b0};
        den    = {55'b0, 1'b1, b[51:0]};
        q      = 56'(num / den);
        sticky = (num % den) != '0;
        e      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
        if (q[55]) begin
            mant   = q[55:3];
            guard  = q[2];
            sticky = sticky | (|q[1:0]);
        end else begin
            mant   = q[54:2];
            guard  = q[1];
            sticky = sticky | q[0];
            e      = e - 13'sd1;
        end
        rnd = {1'b0, mant} + 54'(guard && (sticky || mant[0]));
        if (rnd[53]) begin
            mant = rnd[53:1];
            e    = e + 13'sd1;
        end else begin
            mant = rnd[52:0];
        end
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
            fp_div = 64'h7FF8000000000000;
        else if (a_inf || b_zero)
            fp_div = {sign, 11'h7FF, 52'b0};
        else if (a_zero || b_inf)
            fp_div = {sign, 63'b0};
        else if (e >= 13'sd2047)
            fp_div = {sign, 11'h7FF, 52'b0};
        else if (e <= 13'sd0)
            fp_div = {sign, 63'b0};
        else
            fp_div = {sign, e[10:0], mant[51:0]};
    endfunction

    logic [63:0]        pipe [LATENCY];
    logic [LATENCY-1:0] vld;

    always_ff @(posedge aclk) begin
        pipe[0] <= fp_div(s_axis_a_tdata, s_axis_b_tdata);
        vld     <= {vld[LATENCY-2:0], s_axis_a_tvalid && s_axis_b_tvalid};
        for (int i = 1; i < LATENCY; i++)
            pipe[i] <= pipe[i-1];
    end

    assign m_axis_result_tdata  = pipe[LATENCY-1];
    assign m_axis_result_tvalid = vld[LATENCY-1];

endmodule

// Functional stand-in for the floating_point_sqrt core, same conventions as the divider above.
module floating_point_sqrt #(
    parameter int LATENCY = 28
) (
    input  logic        aclk,
    input  logic        s_axis_a_tvalid,
    input  logic [63:0] s_axis_a_tdata,
    output logic        m_axis_result_tvalid,
    output logic [63:0] m_axis_result_tdata
);

    function automatic logic [63:0] fp_sqrt(input logic [63:0] a);
        logic               a_nan, a_inf, a_zero, guard, sticky;
        logic [10:0]        ea;
        logic [53:0]        m;
        logic [109:0]       rad;
        logic [59:0]        rem, trial;
        logic [54:0]        root;
        logic [52:0]        mant;
        logic [53:0]        rnd;
        logic signed [12:0] e;
        ea     = a[62:52];
        a_nan  = (ea == 11'h7FF) && (a[51:0] != '0);
        a_inf  = (ea == 11'h7FF) && (a[51:0] == '0);
        a_zero = (ea == 11'h000);
        // An even unbiased exponent lets the root exponent be a plain halving.
        e      = $signed({2'b00, ea}) - 13'sd1023;
        if (e[0]) begin
            m = {1'b1, a[51:0], 1'b0};
            e = e - 13'sd1;
        end else begin
            m = {1'b0, 1'b1, a[51:0]};
        end
        rad  = {m, 56'b0};
        rem  = '0;
        root = '0;
        for (int i = 54; i >= 0; i--) begin
            rem   = {rem[57:0], rad[2*i +: 2]};
            trial = {3'b000, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[53:0], 1'b1};
            end else begin
                root = {root[53:0], 1'b0};
            end
        end
        mant   = root[54:2];
        guard  = root[1];
        sticky = root[0] | (rem != '0);
        e      = (e >>> 1) + 13'sd1023;
        rnd    = {1'b0, mant} + 54'(guard && (sticky || mant[0]));
        if (rnd[53]) begin
            mant = rnd[53:1];
            e    = e + 13'sd1;
        end else begin
            mant = rnd[52:0];
        end
        if (a_nan)
            fp_sqrt = 64'h7FF8000000000000;
        else if (a_zero)
            fp_sqrt = {a[63], 63'b0};
        else if (a[63])
            fp_sqrt = 64'h7FF8000000000000;
        else if (a_inf)
            fp_sqrt = 64'h7FF0000000000000;
        else
            fp_sqrt = {1'b0, e[10:0], mant[51:0]};
    endfunction

    logic [63:0]        pipe [LATENCY];
    logic [LATENCY-1:0] vld;

    always_ff @(posedge aclk) begin
        pipe[0] <= fp_sqrt(s_axis_a_tdata);
        vld     <= {vld[LATENCY-2:0], s_axis_a_tvalid};
        for (int i = 1; i < LATENCY; i++)
            pipe[i] <= pipe[i-1];
    end

    assign m_axis_result_tdata  = pipe[LATENCY-1];
    assign m_axis_result_tvalid = vld[LATENCY-1];

endmodule

module pe_typed_stream #(
    parameter int DWIDTH     = 64,
    parameter int DIV_LAT    = 29,
    parameter int SQRT_LAT   = 28,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] inp1,
    input  logic [DWIDTH-1:0] inp2,
    input  logic [1:0]        op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out1,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        out_op
);

    localparam int LAT   = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int EW    = DWIDTH + 2 + TAG_W;
    localparam logic [DWIDTH-1:0] FP_ONE   = DWIDTH'(64'h3FF0000000000000);
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic              accept, pop, empty, wr_en;
    logic [DWIDTH-1:0] div_a, div_res, sqrt_res, div_aligned, sqrt_aligned, result;
    logic              div_tvalid_unused, sqrt_tvalid_unused;

    assign accept = in_valid && in_ready;
    assign div_a  = (op == 2'b10) ? FP_ONE : inp1;

    floating_point_div #(.LATENCY(DIV_LAT)) u_div (
        .aclk                 (clk),
        .s_axis_a_tvalid      (accept),
        .s_axis_a_tdata       (div_a),
        .s_axis_b_tvalid      (accept),
        .s_axis_b_tdata       (inp2),
        .m_axis_result_tvalid (div_tvalid_unused),
        .m_axis_result_tdata  (div_res)
    );

    floating_point_sqrt #(.LATENCY(SQRT_LAT)) u_sqrt (
        .aclk                 (clk),
        .s_axis_a_tvalid      (accept),
        .s_axis_a_tdata       (inp1),
        .m_axis_result_tvalid (sqrt_tvalid_unused),
        .m_axis_result_tdata  (sqrt_res)
    );

    // The faster core gets padding registers so both results line up with the tag pipeline.
    if (LAT > DIV_LAT) begin : g_div_pad
        logic [DWIDTH-1:0] pad [LAT-DIV_LAT];
        always_ff @(posedge clk) begin
            pad[0] <= div_res;
            for (int i = 1; i < LAT - DIV_LAT; i++)
                pad[i] <= pad[i-1];
        end
        assign div_aligned = pad[LAT-DIV_LAT-1];
    end else begin : g_div_direct
        assign div_aligned = div_res;
    end

    if (LAT > SQRT_LAT) begin : g_sqrt_pad
        logic [DWIDTH-1:0] pad [LAT-SQRT_LAT];
        always_ff @(posedge clk) begin
            pad[0] <= sqrt_res;
            for (int i = 1; i < LAT - SQRT_LAT; i++)
                pad[i] <= pad[i-1];
        end
        assign sqrt_aligned = pad[LAT-SQRT_LAT-1];
    end else begin : g_sqrt_direct
        assign sqrt_aligned = sqrt_res;
    end

    logic [LAT-1:0]    tp_valid;
    logic [1:0]        tp_op     [LAT];
    logic [TAG_W-1:0]  tp_tag    [LAT];
    logic [DWIDTH-1:0] pass_pipe [LAT];

    // Only the valid bits need reset; stale op/tag/data behind a cleared valid is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tp_valid <= '0;
        else
            tp_valid <= {tp_valid[LAT-2:0], accept};
    end

    always_ff @(posedge clk) begin
        tp_op[0]     <= op;
        tp_tag[0]    <= in_tag;
        pass_pipe[0] <= inp1;
        for (int i = 1; i < LAT; i++) begin
            tp_op[i]     <= tp_op[i-1];
            tp_tag[i]    <= tp_tag[i-1];
            pass_pipe[i] <= pass_pipe[i-1];
        end
    end

    always_comb begin
        result = pass_pipe[LAT-1];
        case (tp_op[LAT-1])
            2'b00, 2'b10: result = div_aligned;
            2'b01:        result = sqrt_aligned;
            default:      result = pass_pipe[LAT-1];
        endcase
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] head;

    assign wr_en = tp_valid[LAT-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {result, tp_op[LAT-1], tp_tag[LAT-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Outputs read zero while empty so reset and idle states never expose stale memory.
    assign empty     = (wr_ptr == rd_ptr);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out1      = empty ? '0 : head[EW-1 -: DWIDTH];
    assign out_op    = empty ? '0 : head[TAG_W +: 2];
    assign out_tag   = empty ? '0 : head[TAG_W-1:0];

    logic [OCC_W-1:0] occ, occ_next;

    always_comb begin
        occ_next = occ;
        if (accept && !pop)
            occ_next = occ + OCC_W'(1);
        else if (pop && !accept)
            occ_next = occ - OCC_W'(1);
    end

    // Every accepted op owns a FIFO slot from accept until pop, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= '0;
            in_ready <= 1'b0;
        end else begin
            occ      <= occ_next;
            in_ready <= (occ_next < OCC_FULL);
        end
    end

endmodule
